// File: rtl/fb_capture_buf_if.sv
// Feedback capture buffer bus: capture-side inputs and readout-side outputs.
interface fb_capture_buf_if #(
    parameter int unsigned DW    = 13,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic          store_strb;
    logic          fb_valid;
    logic [DW-1:0] fb_sgnl;
    logic          oflow;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_oflow;
    logic [PW-1:0] cap_count;
    logic          ready;
    logic          drop;

    // Driver of stimulus / consumer of readout
    modport master (
        output store_strb, fb_valid, fb_sgnl, oflow, rd_req,
        input  rd_data, rd_valid, rd_oflow, cap_count, ready, drop
    );

    // The capture buffer itself
    modport slave (
        input  store_strb, fb_valid, fb_sgnl, oflow, rd_req,
        output rd_data, rd_valid, rd_oflow, cap_count, ready, drop
    );
endinterface

// File: rtl/fb_capture_buf.sv
// Feedback DAC capture buffer: records fb_sgnl samples during a store_strb
// window, then plays them back one entry per rd_req.
// Optional feature macro: FB_CAPTURE_OFLOW_TAG_EN stores the oflow flag
// per entry and returns it on rd_oflow; otherwise rd_oflow is tied to 0.
module fb_capture_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    fb_capture_buf_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_e;

    state_e        state_q, state_d;
    logic          store_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] cap_count_q, cap_count_d;
    logic          drop_q, drop_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ready_q;
    logic [DW-1:0] rd_data_q;
    logic          rise_c, fall_c, full_c, wr_en_c, rd_en_c;

    logic [DW-1:0] mem [DEPTH];

    // Next-state, pointer and strobe decode
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cap_count_d = cap_count_q;
        drop_d      = drop_q;
        rd_valid_d  = 1'b0;
        wr_en_c     = 1'b0;
        rd_en_c     = 1'b0;
        rise_c      = bus.store_strb & ~store_q;
        fall_c      = ~bus.store_strb & store_q;
        full_c      = (cap_count_q == PW'(DEPTH));

        if (rise_c) begin
            // A new window always restarts capture, discarding unread data
            state_d     = ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cap_count_d = '0;
            drop_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (bus.fb_valid) begin
                        if (full_c) begin
                            drop_d = 1'b1;
                        end else begin
                            wr_en_c     = 1'b1;
                            wr_ptr_d    = wr_ptr_q + PW'(1);
                            cap_count_d = cap_count_q + PW'(1);
                        end
                    end
                    if (fall_c) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // Only reachable with nothing to read when the window was empty
                    if (rd_ptr_q == cap_count_q) begin
                        state_d = IDLE;
                    end else if (bus.rd_req) begin
                        rd_en_c    = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + PW'(1);
                        if (rd_ptr_d == cap_count_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b1;  // a strobe already high at release is not an edge
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cap_count_q <= '0;
            drop_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            ready_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            store_q     <= bus.store_strb;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cap_count_q <= cap_count_d;
            drop_q      <= drop_d;
            rd_valid_q  <= rd_valid_d;
            ready_q     <= (state_d == HOLD);
            if (rd_en_c) begin
                rd_data_q <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    // Sample storage write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.fb_sgnl;
        end
    end

`ifdef FB_CAPTURE_OFLOW_TAG_EN
    logic tag_mem [DEPTH];
    logic rd_oflow_q;

    // Overflow tag write port, alongside the sample
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            tag_mem[wr_ptr_q[AW-1:0]] <= bus.oflow;
        end
    end

    // Overflow tag read register, same timing as rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_oflow_q <= 1'b0;
        end else if (rd_en_c) begin
            rd_oflow_q <= tag_mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign bus.rd_oflow = rd_oflow_q;
`else
    logic unused_oflow;
    assign unused_oflow = bus.oflow;
    assign bus.rd_oflow = 1'b0;
`endif

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.cap_count = cap_count_q;
    assign bus.ready     = ready_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_fb_capture_buf.sv
// Directed bench for fb_capture_buf: cycle table plus multi-cycle sequences.
module tb_fb_capture_buf;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 13;
`ifdef FB_CAPTURE_OFLOW_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    typedef struct {
        logic          strb;
        logic          fv;
        logic [DW-1:0] d;
        logic          of;
        logic          rq;
        logic          ev;
        logic [DW-1:0] ed;
        logic [4:0]    ecc;
        logic          erdy;
        logic          edrop;
        logic          eof;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [19];

    fb_capture_buf_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    fb_capture_buf #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic cyc(input logic strb, input logic fv, input logic [DW-1:0] d,
                       input logic of, input logic rq);
        bus.store_strb = strb;
        bus.fb_valid   = fv;
        bus.fb_sgnl    = d;
        bus.oflow      = of;
        bus.rd_req     = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] last_d;
        rst_n          = 1'b0;
        bus.store_strb = 1'b0;
        bus.fb_valid   = 1'b0;
        bus.fb_sgnl    = '0;
        bus.oflow      = 1'b0;
        bus.rd_req     = 1'b0;

        //          strb fv  d         of  rq  ev  ed        ecc  rdy drop eof
        tbl[0]  = '{1'b0,1'b0,13'h0000,1'b0,1'b0,1'b0,13'h0000,5'd0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,13'h0000,1'b0,1'b0,1'b0,13'h0000,5'd0,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,13'h0010,1'b1,1'b0,1'b0,13'h0000,5'd1,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,13'h1FF0,1'b0,1'b0,1'b0,13'h0000,5'd2,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,13'h0FFF,1'b1,1'b0,1'b0,13'h0000,5'd3,1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,13'h0000,1'b0,1'b0,1'b0,13'h0000,5'd3,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b1,13'h0010,5'd3,1'b1,1'b0,1'b1};
        tbl[7]  = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b1,13'h1FF0,5'd3,1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b1,13'h0FFF,5'd3,1'b0,1'b0,1'b1};
        tbl[9]  = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b0,13'h0FFF,5'd3,1'b0,1'b0,1'b1};
        tbl[10] = '{1'b1,1'b0,13'h0000,1'b0,1'b0,1'b0,13'h0FFF,5'd0,1'b0,1'b0,1'b1};
        tbl[11] = '{1'b1,1'b1,13'h0123,1'b0,1'b0,1'b0,13'h0FFF,5'd1,1'b0,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b1,13'h0ABC,1'b1,1'b0,1'b0,13'h0FFF,5'd2,1'b1,1'b0,1'b1};
        tbl[13] = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b1,13'h0123,5'd2,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b1,13'h0ABC,5'd2,1'b0,1'b0,1'b1};
        tbl[15] = '{1'b1,1'b0,13'h0000,1'b0,1'b0,1'b0,13'h0ABC,5'd0,1'b0,1'b0,1'b1};
        tbl[16] = '{1'b0,1'b0,13'h0000,1'b0,1'b0,1'b0,13'h0ABC,5'd0,1'b1,1'b0,1'b1};
        tbl[17] = '{1'b0,1'b0,13'h0000,1'b0,1'b1,1'b0,13'h0ABC,5'd0,1'b0,1'b0,1'b1};
        tbl[18] = '{1'b0,1'b1,13'h0777,1'b1,1'b0,1'b0,13'h0ABC,5'd0,1'b0,1'b0,1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("reset rd_data",   32'(bus.rd_data),   32'd0);
        chk("reset cap_count", 32'(bus.cap_count), 32'd0);
        chk("reset ready",     32'(bus.ready),     32'd0);
        chk("reset drop",      32'(bus.drop),      32'd0);
        rst_n = 1'b1;

        // Cycle table: basic capture/readout, coincident fall, empty window, idle fb_valid
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].strb, tbl[i].fv, tbl[i].d, tbl[i].of, tbl[i].rq);
            chk($sformatf("vec%0d rd_valid", i),  32'(bus.rd_valid),  32'(tbl[i].ev));
            chk($sformatf("vec%0d rd_data", i),   32'(bus.rd_data),   32'(tbl[i].ed));
            chk($sformatf("vec%0d cap_count", i), 32'(bus.cap_count), 32'(tbl[i].ecc));
            chk($sformatf("vec%0d ready", i),     32'(bus.ready),     32'(tbl[i].erdy));
            chk($sformatf("vec%0d drop", i),      32'(bus.drop),      32'(tbl[i].edrop));
            chk($sformatf("vec%0d rd_oflow", i),  32'(bus.rd_oflow),  32'(TAG & tbl[i].eof));
        end

        // Overfill: 20 samples into 16 entries
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 13'(i * 37 + 5), i[0], 1'b0);
            if (i == 15) begin
                chk("full cap_count", 32'(bus.cap_count), 32'd16);
                chk("full no drop yet", 32'(bus.drop), 32'd0);
            end
        end
        chk("ovf cap_count", 32'(bus.cap_count), 32'd16);
        chk("ovf drop",      32'(bus.drop),      32'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
            chk($sformatf("ovf rd%0d valid", i), 32'(bus.rd_valid), 32'd1);
            chk($sformatf("ovf rd%0d data", i),  32'(bus.rd_data),  32'(13'(i * 37 + 5)));
            chk($sformatf("ovf rd%0d oflow", i), 32'(bus.rd_oflow), 32'(TAG & i[0]));
        end
        chk("ovf end ready", 32'(bus.ready), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("ovf extra rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("ovf extra rd_data",  32'(bus.rd_data),  32'(13'(15 * 37 + 5)));
        chk("ovf drop sticky",    32'(bus.drop),     32'd1);

        // Re-arm during HOLD with partial readout and a coincident rd_req
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 13'(16'h0200 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rearm rd0", 32'(bus.rd_data), 32'h0200);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rearm rd1", 32'(bus.rd_data), 32'h0201);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("rearm rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("rearm cap_count", 32'(bus.cap_count), 32'd0);
        chk("rearm drop",      32'(bus.drop),      32'd0);
        chk("rearm ready",     32'(bus.ready),     32'd0);
        cyc(1'b1, 1'b1, 13'h0055, 1'b0, 1'b0);
        chk("rearm armed cap", 32'(bus.cap_count), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rearm first entry valid", 32'(bus.rd_valid), 32'd1);
        chk("rearm first entry data",  32'(bus.rd_data),  32'h0055);
        last_d = bus.rd_data;

        // Asynchronous reset mid-capture, then no arming on a held strobe
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 13'(16'h0300 + i), 1'b1, 1'b0);
        chk("prerst cap_count", 32'(bus.cap_count), 32'd4);
        chk("prerst rd_data",   32'(bus.rd_data),   32'(last_d));
        #2 rst_n = 1'b0;
        #1;
        chk("rst rd_data",   32'(bus.rd_data),   32'd0);
        chk("rst rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("rst rd_oflow",  32'(bus.rd_oflow),  32'd0);
        chk("rst cap_count", 32'(bus.cap_count), 32'd0);
        chk("rst ready",     32'(bus.ready),     32'd0);
        chk("rst drop",      32'(bus.drop),      32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 13'h0444, 1'b0, 1'b0);
        chk("postrst no arm cap", 32'(bus.cap_count), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("postrst no hold", 32'(bus.ready), 32'd0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 13'h0555, 1'b0, 1'b0);
        chk("postrst rearm cap", 32'(bus.cap_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
